acq_controller: RTL

Multi-channel acquisition sequencer for the scope datapath. It turns front-panel RUN/STOP and SINGLE buttons into start/stop handshakes for up to `NUM_CH` capture engines. Compared with the single-channel controller, it adds per-channel enables, a programmable post-acquisition holdoff, and an acquisition counter. It also adds an optional auto-trigger timeout that forces a trigger when none arrives. It sits between the user-input debouncers and the capture/trigger engines.

---
 rtl/scope_pkg.sv | 20 ++
 rtl/acq_controller_if.sv | 27 ++
 rtl/btn_edge.sv | 23 ++
 rtl/acq_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and default constants for the scope acquisition sequencer.
//   acq_state_t : sequencer states IDLE -> START -> WAIT_DONE -> STOP -> HOLDOFF
//   DEF_*       : default parameter values used by acq_controller
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        STOP,
        HOLDOFF
    } acq_state_t;

    localparam int          DEF_NUM_CH       = 2;
    localparam int          DEF_HOLDOFF_W    = 16;
    localparam int          DEF_TIMEOUT_W    = 24;
    localparam int unsigned DEF_AUTO_TIMEOUT = 1_000_000;
    localparam int          DEF_CNT_W        = 16;

endpackage

// File: rtl/acq_controller_if.sv
// Start/stop handshake bundle between the acquisition sequencer and the
// capture/trigger engines.
//   o_start      : per-channel start request (sequencer -> engines)
//   i_busy       : per-channel capture in progress (engines -> sequencer)
//   i_done       : per-channel capture complete level (engines -> sequencer)
//   o_stop       : completion acknowledge, broadcast to all channels
//   o_force_trig : one-cycle forced-trigger pulse to the trigger engines
// Modports: master = sequencer side, slave = engine side.
interface acq_controller_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0] o_start;
    logic [NUM_CH-1:0] i_busy;
    logic [NUM_CH-1:0] i_done;
    logic              o_stop;
    logic              o_force_trig;

    modport master (
        output o_start, o_stop, o_force_trig,
        input  i_busy, i_done
    );

    modport slave (
        input  o_start, o_stop, o_force_trig,
        output i_busy, i_done
    );
endinterface

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a debounced button level.
//   i_clk, i_rst : clock and synchronous active-high reset
//   i_lvl        : debounced button level
//   o_pulse      : registered one-cycle pulse, high after the edge that first
//                  samples i_lvl high
module btn_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lvl,
    output logic o_pulse
);
    logic lvl_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lvl_q   <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            lvl_q   <= i_lvl;
            o_pulse <= i_lvl & ~lvl_q;
        end
    end
endmodule

// File: rtl/acq_controller.sv
// Multi-channel acquisition sequencer: turns RUN/STOP and SINGLE buttons into
// start/stop handshakes for NUM_CH capture engines run in lockstep, with a
// programmable post-acquisition holdoff and a completed-acquisition counter.
// Optional feature macro: ACQ_AUTO_TRIG_EN builds the auto-trigger timeout
// (forced trigger after AUTO_TIMEOUT cycles in WAIT_DONE when i_auto = 1);
// without it o_force_trig is tied low and i_auto is ignored.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_run_stop       : RUN/STOP level, each rising edge toggles continuous run
//   i_single         : SINGLE level, rising edge requests one acquisition, cancels run
//   i_auto           : 1 = auto trigger mode, 0 = normal
//   i_ch_en          : channel enable mask, latched on entry to START
//   i_holdoff        : idle cycles after each acquisition, latched on STOP exit
//   cap (master)     : o_start / i_busy / i_done / o_stop / o_force_trig handshake
//   o_running        : run set, single pending, or sequencer not idle
//   o_acq_cnt        : completed acquisitions, wraps
module acq_controller
    import scope_pkg::*;
#(
    parameter int          NUM_CH       = DEF_NUM_CH,
    parameter int          HOLDOFF_W    = DEF_HOLDOFF_W,
    parameter int          TIMEOUT_W    = DEF_TIMEOUT_W,
    parameter int unsigned AUTO_TIMEOUT = DEF_AUTO_TIMEOUT,
    parameter int          CNT_W        = DEF_CNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_run_stop,
    input  logic                 i_single,
    input  logic                 i_auto,
    input  logic [NUM_CH-1:0]    i_ch_en,
    input  logic [HOLDOFF_W-1:0] i_holdoff,
    acq_controller_if.master     cap,
    output logic                 o_running,
    output logic [CNT_W-1:0]     o_acq_cnt
);
    logic rs_p;
    logic sg_p;

    btn_edge u_rs_edge (.i_clk(i_clk), .i_rst(i_rst), .i_lvl(i_run_stop), .o_pulse(rs_p));
    btn_edge u_sg_edge (.i_clk(i_clk), .i_rst(i_rst), .i_lvl(i_single),   .o_pulse(sg_p));

    acq_state_t           state_q, state_d;
    logic                 run_q, run_d;
    logic                 pend_q, pend_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [NUM_CH-1:0]    start_q, start_d;
    logic                 stop_q, stop_d;
    logic                 running_q, running_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [HOLDOFF_W-1:0] hold_q, hold_d;
    logic                 all_busy, all_done, none_done;

    // Disabled channels are forced to "agree" so they never block a transition.
    assign all_busy  = ((cap.i_busy & mask_q) == mask_q);
    assign all_done  = ((cap.i_done & mask_q) == mask_q);
    assign none_done = ((cap.i_done & mask_q) == '0);

`ifdef ACQ_AUTO_TRIG_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(AUTO_TIMEOUT - 1);
    logic [TIMEOUT_W-1:0] to_q, to_d;
    logic                 fired_q, fired_d;
    logic                 force_q, force_d;
`else
    localparam int unused_timeout_cfg = TIMEOUT_W + int'(AUTO_TIMEOUT);
    logic unused_auto;
    assign unused_auto = i_auto;
`endif

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        pend_d  = pend_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                // An empty enable mask keeps the request pending until a channel is enabled.
                if ((run_q | pend_q) && (i_ch_en != '0)) begin
                    state_d = START;
                    mask_d  = i_ch_en;
                    pend_d  = 1'b0;
                end
            end
            START: begin
                if (all_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (all_done) state_d = STOP;
            end
            STOP: begin
                if (none_done) begin
                    state_d = HOLDOFF;
                    cnt_d   = cnt_q + CNT_W'(1);
                    hold_d  = i_holdoff;
                end
            end
            HOLDOFF: begin
                if (hold_q == '0) state_d = IDLE;
                else              hold_d  = hold_q - HOLDOFF_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Button pulses only change the request flags; an acquisition in flight always completes.
        if (sg_p) begin
            run_d  = 1'b0;
            pend_d = 1'b1;
        end else if (rs_p) begin
            run_d = ~run_q;
        end

        // Outputs are decoded from next-state so they switch on the transition edge.
        start_d   = (state_d == START) ? mask_d : '0;
        stop_d    = (state_d == STOP);
        running_d = run_d | pend_d | (state_d != IDLE);

`ifdef ACQ_AUTO_TRIG_EN
        to_d    = to_q;
        fired_d = fired_q;
        if (state_q == START) begin
            to_d    = '0;
            fired_d = 1'b0;
        end else if ((state_q == WAIT_DONE) && (to_q != '1)) begin
            to_d = to_q + TIMEOUT_W'(1);
        end
        force_d = (state_d == WAIT_DONE) && (to_d == TO_LAST) && i_auto && !fired_d;
        if (force_d) fired_d = 1'b1;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            pend_q    <= 1'b0;
            start_q   <= '0;
            stop_q    <= 1'b0;
            running_q <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            pend_q    <= pend_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            running_q <= running_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
        end
    end

    // The mask is only consulted after it has been latched on START entry.
    always_ff @(posedge i_clk) begin
        mask_q <= mask_d;
    end

`ifdef ACQ_AUTO_TRIG_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_q    <= '0;
            fired_q <= 1'b0;
            force_q <= 1'b0;
        end else begin
            to_q    <= to_d;
            fired_q <= fired_d;
            force_q <= force_d;
        end
    end
    assign cap.o_force_trig = force_q;
`else
    assign cap.o_force_trig = 1'b0;
`endif

    assign cap.o_start = start_q;
    assign cap.o_stop  = stop_q;
    assign o_running   = running_q;
    assign o_acq_cnt   = cnt_q;
endmodule
